// File: rtl/krnl_msm_381_pkg.sv
// Shared constants and types for the BLS12-381 MSM kernel.
// Scalars are recoded into signed 13-bit windows dispatched P_NUM_ACCU at a time.
package krnl_msm_381_pkg;

    localparam int P_RED_SCLR_W = 13;
    localparam int P_NUM_ACCU   = 2;
    localparam int P_NUM_WIN    = 10;
    localparam int P_TOTAL_WIN  = 20;
    localparam int P_FUL_SCLR_W = 256;

    localparam int P_SCLR_PAD_W = P_TOTAL_WIN * P_RED_SCLR_W;
    localparam int P_STEP_W     = $clog2(P_NUM_WIN);
    localparam int P_HALF_BKT   = 2 ** (P_RED_SCLR_W - 1);
    localparam int P_STEP_BITS  = P_NUM_ACCU * P_RED_SCLR_W;

    typedef struct packed {
        logic [P_RED_SCLR_W-1:0] mag;
        logic                    sign;
    } dgt_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_EMIT = 2'd2,
        ST_DONE = 2'd3
    } sched_state_e;

endpackage

// File: rtl/krnl_msm_381_dgt_recode.sv
// One window of signed-digit recoding: t = slice + carry; t >= half bucket
// wraps to t - 2^13 with an outgoing carry. Zero digits always carry sign 0.
module krnl_msm_381_dgt_recode
    import krnl_msm_381_pkg::*;
(
    input  logic [P_RED_SCLR_W-1:0] slice_i,
    input  logic                    carry_i,
    output dgt_t                    dgt_o,
    output logic                    carry_o
);

    localparam logic [P_RED_SCLR_W:0] L_MOD  = (P_RED_SCLR_W+1)'(2 * P_HALF_BKT);
    localparam logic [P_RED_SCLR_W:0] L_HALF = (P_RED_SCLR_W+1)'(P_HALF_BKT);

    logic [P_RED_SCLR_W:0] t;
    logic [P_RED_SCLR_W:0] neg_mag;

    always_comb begin
        t       = {1'b0, slice_i} + {{P_RED_SCLR_W{1'b0}}, carry_i};
        carry_o = (t >= L_HALF);
        // t = 2^13 (all-ones slice plus carry) wraps to a zero digit.
        neg_mag = L_MOD - t;
        dgt_o.mag  = carry_o ? neg_mag[P_RED_SCLR_W-1:0] : t[P_RED_SCLR_W-1:0];
        dgt_o.sign = carry_o & (|dgt_o.mag);
    end

endmodule

// File: rtl/krnl_msm_381_sclr_sched.sv
// Scalar scheduler: loads one scalar per point and streams its recoded windows,
// P_NUM_ACCU lanes per step. Handshakes: a transfer happens on a rising edge where valid & ready.
module krnl_msm_381_sclr_sched
    import krnl_msm_381_pkg::*;
#(
    parameter int P_PNT_IDX_W = 32
) (
    input  logic                                     ap_clk,
    input  logic                                     ap_rst_n,
    input  logic                                     ctrl_start,
    input  logic [P_PNT_IDX_W-1:0]                   ctrl_num_pnt,
    output logic                                     ctrl_busy,
    output logic                                     ctrl_done,
    input  logic                                     s_sclr_valid,
    output logic                                     s_sclr_ready,
    input  logic [P_FUL_SCLR_W-1:0]                  s_sclr_data,
    output logic                                     m_dgt_valid,
    input  logic                                     m_dgt_ready,
    output logic [P_NUM_ACCU-1:0][P_RED_SCLR_W-1:0]  m_dgt_mag,
    output logic [P_NUM_ACCU-1:0]                    m_dgt_sign,
    output logic [P_STEP_W-1:0]                      m_dgt_step,
    output logic [P_PNT_IDX_W-1:0]                   m_dgt_pnt_idx,
    output logic                                     m_dgt_last,
    output logic [1:0]                               dbg_state_o
);

    localparam logic [P_STEP_W-1:0] L_K_LAST = P_STEP_W'(P_NUM_WIN - 1);
    localparam logic [P_STEP_W-1:0] L_K_PENU = P_STEP_W'(P_NUM_WIN - 2);

    sched_state_e              state_q, state_d;
    logic [P_PNT_IDX_W-1:0]    num_q, num_d;
    logic [P_PNT_IDX_W-1:0]    pnt_cnt_q, pnt_cnt_d;
    logic [P_STEP_W-1:0]       k_q, k_d;
    logic                      carry_q, carry_d;
    logic [P_SCLR_PAD_W-1:0]   sclr_q, sclr_d;
    dgt_t [P_NUM_ACCU-1:0]     dgt_q, dgt_d;
    logic                      last_q, last_d;

    logic [P_SCLR_PAD_W-1:0]   sclr_pad;
    logic [P_SCLR_PAD_W-1:0]   rec_src;
    logic [P_NUM_ACCU:0]       rec_carry;
    dgt_t [P_NUM_ACCU-1:0]     rec_dgt;
    logic                      last_pnt;

    // The recoder chain sees the incoming scalar while loading (windows 0/1 with
    // zero carry) and the shifted remainder plus registered carry while emitting.
    assign sclr_pad     = P_SCLR_PAD_W'(s_sclr_data);
    assign rec_src      = (state_q == ST_LOAD) ? sclr_pad : sclr_q;
    assign rec_carry[0] = (state_q == ST_LOAD) ? 1'b0 : carry_q;
    assign last_pnt     = (pnt_cnt_q == num_q - P_PNT_IDX_W'(1));

    for (genvar a = 0; a < P_NUM_ACCU; a++) begin : g_lane
        krnl_msm_381_dgt_recode u_recode (
            .slice_i (rec_src[a*P_RED_SCLR_W +: P_RED_SCLR_W]),
            .carry_i (rec_carry[a]),
            .dgt_o   (rec_dgt[a]),
            .carry_o (rec_carry[a+1])
        );
        assign m_dgt_mag[a]  = dgt_q[a].mag;
        assign m_dgt_sign[a] = dgt_q[a].sign;
    end

    always_comb begin
        state_d   = state_q;
        num_d     = num_q;
        pnt_cnt_d = pnt_cnt_q;
        k_d       = k_q;
        carry_d   = carry_q;
        sclr_d    = sclr_q;
        dgt_d     = dgt_q;
        last_d    = last_q;
        case (state_q)
            ST_IDLE: begin
                if (ctrl_start) begin
                    num_d     = ctrl_num_pnt;
                    pnt_cnt_d = '0;
                    state_d   = (ctrl_num_pnt == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (s_sclr_valid) begin
                    sclr_d  = sclr_pad >> P_STEP_BITS;
                    carry_d = rec_carry[P_NUM_ACCU];
                    k_d     = '0;
                    dgt_d   = rec_dgt;
                    // Step 0 is never the final step with more than one window pair.
                    last_d  = 1'b0;
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (m_dgt_ready) begin
                    if (k_q != L_K_LAST) begin
                        k_d     = k_q + P_STEP_W'(1);
                        sclr_d  = sclr_q >> P_STEP_BITS;
                        carry_d = rec_carry[P_NUM_ACCU];
                        dgt_d   = rec_dgt;
                        last_d  = (k_q == L_K_PENU) && last_pnt;
                    end else begin
                        pnt_cnt_d = pnt_cnt_q + P_PNT_IDX_W'(1);
                        last_d    = 1'b0;
                        state_d   = last_pnt ? ST_DONE : ST_LOAD;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q   <= ST_IDLE;
            num_q     <= '0;
            pnt_cnt_q <= '0;
            k_q       <= '0;
            carry_q   <= 1'b0;
            sclr_q    <= '0;
            dgt_q     <= '0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            num_q     <= num_d;
            pnt_cnt_q <= pnt_cnt_d;
            k_q       <= k_d;
            carry_q   <= carry_d;
            sclr_q    <= sclr_d;
            dgt_q     <= dgt_d;
            last_q    <= last_d;
        end
    end

    assign s_sclr_ready  = (state_q == ST_LOAD);
    assign m_dgt_valid   = (state_q == ST_EMIT);
    assign ctrl_busy     = (state_q != ST_IDLE);
    assign ctrl_done     = (state_q == ST_DONE);
    assign m_dgt_step    = k_q;
    assign m_dgt_pnt_idx = pnt_cnt_q;
    assign m_dgt_last    = last_q;
    assign dbg_state_o   = state_q;

endmodule

// File: doc/krnl_msm_381_sclr_sched.md
# krnl_msm_381_sclr_sched

Scalar scheduler for the BLS12-381 MSM kernel. Accepts one 256-bit scalar per point and recodes it into P_TOTAL_WIN signed 13-bit digits (windows). It dispatches those digits, P_NUM_ACCU windows per cycle, to the bucket accumulators over P_NUM_WIN steps, tagging each step with point index and window step. It sits between the scalar input stream and the accumulator array, and owns the run-level start/done sequencing.

## Interface
Parameters:
- P_PNT_IDX_W, 32, width of point counter/index.
- P_RED_SCLR_W, P_NUM_ACCU, P_NUM_WIN, P_TOTAL_WIN, P_FUL_SCLR_W, taken from krnl_msm_381_pkg (13, 2, 10, 20, 256).

Ports (one clock; reset is asynchronous and active-low):
- ap_clk  in  1  kernel clock.
- ap_rst_n  in  1  async active-low reset.
- ctrl_start  in  1  one-cycle run start pulse.
- ctrl_num_pnt  in  P_PNT_IDX_W  number of scalars in the run; sampled on accepted start.
- ctrl_busy  out  1  high from accepted start until done.
- ctrl_done  out  1  one-cycle pulse at end of run.
- s_sclr_valid  in  1  scalar valid.
- s_sclr_ready  out  1  scalar accepted when valid & ready.
- s_sclr_data  in  P_FUL_SCLR_W  unsigned scalar.
- m_dgt_valid  out  1  digit bundle valid (all lanes).
- m_dgt_ready  in  1  accumulator array ready (common to all lanes).
- m_dgt_mag  out  P_NUM_ACCU x P_RED_SCLR_W  per-lane digit magnitude, 0..4096.
- m_dgt_sign  out  P_NUM_ACCU  per-lane sign; 1 means negative (subtract point).
- m_dgt_step  out  $clog2(P_NUM_WIN)  step k, 0..P_NUM_WIN-1.
- m_dgt_pnt_idx  out  P_PNT_IDX_W  index of the source scalar, 0-based.
- m_dgt_last  out  1  last step of last scalar of the run.

## Operation
- Window w covers scalar bits [13w+12:13w]. Scalar is zero-extended to P_TOTAL_WIN*13 = 260 bits.
- Lane a at step k carries window w = k*P_NUM_ACCU + a, so a cycle emits windows 2k and 2k+1.
- Recode per window: t = slice + carry_in.
  - If t >= 4096: digit = t - 8192 and carry_out = 1.
  - Otherwise digit = t and carry_out = 0.
  - Digit range is [-4096, 4095]. The output is the magnitude plus a sign bit; zero always has sign 0.
  - carry_in of window 0 is 0. Carry chains combinationally from lane 0 to lane 1 within a step, and is registered between steps.
  - Window 19 holds at most 9 significant bits plus the carry, so a final carry never occurs.
- Zero digits are emitted, not skipped.
- FSM:
  - IDLE: busy=0. ctrl_start goes to LOAD with pnt_cnt=0 and captures num. If num=0, go to DONE instead.
  - LOAD: s_sclr_ready=1. On handshake, register the scalar, clear carry and k, and go to EMIT.
  - EMIT: m_dgt_valid=1. On handshake with k<P_NUM_WIN-1, increment k and advance carry. On handshake with k=P_NUM_WIN-1, increment pnt_cnt; go to LOAD if pnt_cnt+1<num, else DONE.
  - DONE: ctrl_done=1 for one cycle, then IDLE.
- ctrl_start is ignored in every state except IDLE.
- m_dgt_last = (k=P_NUM_WIN-1) & (pnt_cnt=num-1).

## Timing
- Reset values: s_sclr_ready=0, m_dgt_valid=0, mag/sign/step/pnt_idx/last=0, ctrl_busy=0, ctrl_done=0. State returns to IDLE immediately on ap_rst_n low, including mid-run. No partial output survives reset.
- Outputs are registered. While valid & !ready, every m_dgt_* field holds stable.
- Scalar handshake to first m_dgt_valid takes 1 cycle.
- Throughput is P_NUM_WIN+1 cycles per scalar when unstalled (one LOAD bubble).
- ctrl_done pulses the cycle after the last digit handshake. ctrl_busy falls with ctrl_done.
- Back-pressure at k=P_NUM_WIN-1 holds state. s_sclr_ready stays 0 until that handshake completes.

## Structure
- Add to krnl_msm_381_pkg:
  - P_SCLR_PAD_W = P_TOTAL_WIN*P_RED_SCLR_W.
  - P_STEP_W = $clog2(P_NUM_WIN).
  - P_HALF_BKT = 2**(P_RED_SCLR_W-1).
  - typedef struct for the digit (mag, sign).
  - State enum typedef.
- Sub-module krnl_msm_381_dgt_recode: combinational; inputs slice and carry_in, outputs mag, sign and carry_out. Instantiate it P_NUM_ACCU times, chained.

## Test plan
- Scalar 1, num=1 → step0: lane0 mag1 sign0, lane1 0; steps 1..9 all zero. At step9 last=1, then done pulse.
- Scalar 0x1000 → step0: lane0 mag4096 sign1, lane1 mag1 sign0; all other steps zero.
- Scalar 2^256-1 → step0 lane0 mag1 sign1; all middle digits 0; step9 lane1 mag512 sign0.
- num=3 with random m_dgt_ready stalls → fields stable under stall, pnt_idx 0,1,2, exactly 30 bundles. A software model reconstructs each scalar as Σ ±mag·2^(13w).
- num=0 → ctrl_done pulses 2 cycles after start; s_sclr_ready never asserts. A start issued while busy is ignored.
- ap_rst_n low at step 4 of point 1 → all outputs 0 and state IDLE. A new start then runs cleanly from pnt_idx 0.
